// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small circular FIFO; queued characters leave back-to-back.
// Frame: start, DATA_BITS LSB first, optional parity, STOP_BITS stop bits.
module uart_tx_fifo #(
    parameter int unsigned BIT_RATE   = 9600,
    parameter int unsigned CLK_HZ     = 12_000_000,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                              CLK,
    input  logic                              RST_N,
    input  logic                              WR,
    input  logic [DATA_BITS-1:0]              DATA,
    output logic                              FULL,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   LEVEL,
    output logic                              BUSY,
    output logic                              TX
);

    localparam int unsigned CPB = CLK_HZ / BIT_RATE;
    localparam int unsigned CW  = $clog2(CPB);
    localparam int unsigned IW  = $clog2(DATA_BITS + 1);
    localparam int unsigned LW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

    if ((DATA_BITS < 5) || (DATA_BITS > 9) || (STOP_BITS < 1) || (STOP_BITS > 2) ||
        (PARITY > 2) || (CPB < 2) || (FIFO_DEPTH < 2) ||
        ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_param_error
        $error("uart_tx_fifo: illegal parameter combination");
    end

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_t;

    state_t               r_state;
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [LW-1:0]        r_level;
    logic                 r_full;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_tx;

    logic                 w_bit_end;
    logic                 w_push;
    logic                 w_pop;
    logic [LW-1:0]        w_level_nxt;
    logic [DATA_BITS-1:0] w_head;

    assign w_bit_end = (r_cnt == CNT_LAST);
    assign w_push    = WR && !r_full;
    // Pop from idle, or on the final stop-bit cycle so the next start bit follows with no gap.
    assign w_pop     = (r_level != '0) &&
                       ((r_state == StIdle) ||
                        ((r_state == StStop) && w_bit_end && (r_idx == STOP_LAST)));
    assign w_head    = r_mem[r_rptr];

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + LW'(1);
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - LW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= DATA;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LVL_FULL);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
        end else if (w_pop) begin
            r_shift <= w_head;
            r_par   <= (PARITY == 1) ? ~^w_head : ^w_head;
            r_tx    <= 1'b0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= StStart;
        end else begin
            case (r_state)
                StIdle: begin
                    r_tx <= 1'b1;
                end
                StStart: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_state <= StData;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                StData: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_idx == DATA_LAST) begin
                            r_idx <= '0;
                            if (PARITY != 0) begin
                                r_tx    <= r_par;
                                r_state <= StParity;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= StStop;
                            end
                        end else begin
                            r_idx   <= r_idx + IW'(1);
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                StParity: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_tx    <= 1'b1;
                        r_state <= StStop;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                StStop: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_idx == STOP_LAST) begin
                            r_idx   <= '0;
                            r_tx    <= 1'b1;
                            r_state <= StIdle;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign FULL  = r_full;
    assign LEVEL = r_level;
    assign BUSY  = (r_state != StIdle) || (r_level != '0);
    assign TX    = r_tx;

endmodule
